// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between requesters, the round-robin arbiter and the mux consumer.
// The arbiter connects through the slave modport; the requester/consumer side uses master.
interface rr_sel_arbiter_if #(
  parameter int unsigned EXP = 5
);
  localparam int unsigned N = 32'(1) << EXP;

  logic [N-1:0]   req;
  logic           out_ready;
  logic           gnt_valid;
  logic [EXP-1:0] sel;
  logic [N-1:0]   gnt_onehot;

  modport master (
    output req, out_ready,
    input  gnt_valid, sel, gnt_onehot
  );

  modport slave (
    input  req, out_ready,
    output gnt_valid, sel, gnt_onehot
  );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered mux-tree select index.
// A grant is held until accepted by a valid/ready handshake; priority rotates past each accepted index.
module rr_sel_arbiter #(
  parameter int unsigned EXP = 5
) (
  input  logic             clk,
  input  logic             reset,
  rr_sel_arbiter_if.slave  bus
);
  localparam int unsigned N = 32'(1) << EXP;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [EXP-1:0] ptr_q, ptr_d;
  logic [EXP-1:0] sel_q, sel_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   onehot_q, onehot_d;

  logic [EXP-1:0] scan_start;
  logic           hit;
  logic [EXP-1:0] hit_idx;

  // First set request bit at or after start, wrapping modulo N; MSB of the result is the found flag.
  function automatic logic [EXP:0] rr_scan(input logic [N-1:0] r, input logic [EXP-1:0] start);
    logic           found;
    logic [EXP-1:0] idx;
    logic [EXP-1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int unsigned i = 0; i < N; i++) begin
      cand = start + EXP'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    onehot_d = onehot_q;

    // In GRANT the only search that matters is the post-handshake one, which starts just past sel.
    scan_start       = (state_q == GRANT) ? (sel_q + EXP'(1)) : ptr_q;
    {hit, hit_idx}   = rr_scan(bus.req, scan_start);

    case (state_q)
      IDLE: begin
        if (hit) begin
          sel_d    = hit_idx;
          valid_d  = 1'b1;
          onehot_d = N'(1) << hit_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (bus.out_ready) begin
          ptr_d = sel_q + EXP'(1);
          if (hit) begin
            sel_d    = hit_idx;
            onehot_d = N'(1) << hit_idx;
          end else begin
            valid_d  = 1'b0;
            onehot_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.sel        = sel_q;
  assign bus.gnt_onehot = onehot_q;

  a_onehot_matches_sel: assert property (@(posedge clk) disable iff (reset)
    onehot_q == (valid_q ? (N'(1) << sel_q) : N'(0)));

  a_sel_stable_on_stall: assert property (@(posedge clk) disable iff (reset)
    (valid_q && !bus.out_ready) |=> $stable(sel_q));
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios with literal expectations, then random traffic,
// with every cycle compared against a queue-free behavioural rotating-priority model.
module tb_rr_sel_arbiter;
  localparam int unsigned EXP = 3;
  localparam int unsigned N   = 1 << EXP;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  rr_sel_arbiter_if #(.EXP(EXP)) bus ();

  rr_sel_arbiter #(.EXP(EXP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: who wins is the first requester found walking the ring from a start index.
  function automatic int first_req(input logic [N-1:0] r, input int start);
    for (int i = 0; i < int'(N); i++) begin
      if (r[(start + i) % int'(N)]) return (start + i) % int'(N);
    end
    return -1;
  endfunction

  int m_valid;
  int m_sel;
  int m_ptr;

  initial begin
    m_valid = 0;
    m_sel   = 0;
    m_ptr   = 0;
  end

  // Advance the model on each edge from the sampled inputs, then compare shortly after.
  always @(posedge clk) begin
    logic [N-1:0] r;
    logic         rdy;
    logic         rs;
    int           k;
    r   = bus.req;
    rdy = bus.out_ready;
    rs  = reset;
    if (rs) begin
      m_valid = 0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (m_valid == 0) begin
      k = first_req(r, m_ptr);
      if (k >= 0) begin
        m_valid = 1;
        m_sel   = k;
      end
    end else if (rdy) begin
      m_ptr = (m_sel + 1) % int'(N);
      k = first_req(r, m_ptr);
      if (k >= 0) m_sel = k;
      else        m_valid = 0;
    end
    #1;
    check("model_valid",  32'(bus.gnt_valid), 32'(m_valid));
    check("model_sel",    32'(bus.sel), 32'(m_sel));
    check("model_onehot", 32'(bus.gnt_onehot), (m_valid != 0) ? (32'(1) << m_sel) : 32'(0));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.req       = 8'hFF;
    bus.out_ready = 1'b0;

    // Reset, then idle
    tick(); tick();
    check("rst_valid",  32'(bus.gnt_valid), 32'd0);
    check("rst_sel",    32'(bus.sel), 32'd0);
    check("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
    reset = 1'b0; bus.req = 8'h00;
    tick();
    check("idle_valid", 32'(bus.gnt_valid), 32'd0);

    // Single grant, stalled, req changes underneath
    bus.req = 8'b0010_0100;
    tick();
    check("grant_valid",  32'(bus.gnt_valid), 32'd1);
    check("grant_sel",    32'(bus.sel), 32'd2);
    check("grant_onehot", 32'(bus.gnt_onehot), 32'h04);
    bus.req = 8'h20;
    repeat (5) tick();
    check("stall_sel",   32'(bus.sel), 32'd2);
    check("stall_valid", 32'(bus.gnt_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("after_hs_sel",   32'(bus.sel), 32'd5);
    check("after_hs_valid", 32'(bus.gnt_valid), 32'd1);

    // Full rotation from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.req = 8'hFF; bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      check("rot_sel",   32'(bus.sel), 32'(i % 8));
      check("rot_valid", 32'(bus.gnt_valid), 32'd1);
    end

    // Wrap-around priority after a handshake on 6
    repeat (6) tick();
    check("pre_wrap_sel", 32'(bus.sel), 32'd6);
    bus.req = 8'b0000_0011;
    tick(); check("wrap_sel0", 32'(bus.sel), 32'd0);
    tick(); check("wrap_sel1", 32'(bus.sel), 32'd1);
    tick(); check("wrap_sel2", 32'(bus.sel), 32'd0);

    // Drain to idle, then restart with ptr=4
    bus.req = 8'h08;
    tick(); check("drain_sel", 32'(bus.sel), 32'd3);
    bus.req = 8'h00;
    tick();
    check("drain_valid",  32'(bus.gnt_valid), 32'd0);
    check("drain_onehot", 32'(bus.gnt_onehot), 32'd0);
    check("drain_keep",   32'(bus.sel), 32'd3);
    bus.out_ready = 1'b0;
    tick(); check("idle_ready_noop", 32'(bus.gnt_valid), 32'd0);
    bus.req = 8'h09;
    tick(); check("restart_sel", 32'(bus.sel), 32'd0);

    // Reset mid-grant clears the pointer
    bus.req = 8'h20; bus.out_ready = 1'b1;
    tick(); check("pre_rst_sel", 32'(bus.sel), 32'd5);
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(bus.gnt_valid), 32'd0);
    check("midrst_sel",   32'(bus.sel), 32'd0);
    reset = 1'b0; bus.req = 8'h30;
    tick(); check("post_rst_sel", 32'(bus.sel), 32'd4);

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       bus.req = '0;
        1:       bus.req = 8'(1) << $urandom_range(0, N - 1);
        default: bus.req = 8'($urandom);
      endcase
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
